// File: rtl/pariVo_fir_pkg.sv
// pariVo_fir_pkg: shared widths, state encoding and sample/accumulator types for the filter path
package pariVo_fir_pkg;
    localparam int NTAPS = 8;
    localparam int TAP_W = 3;
    localparam int DATA_W = 16;
    localparam int ACC_W = 35;
    localparam int FRAC_BITS = 15;
    typedef enum logic [1:0] {IDLE, MAC, DONE} fir_state_t;
    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0] acc_t;
endpackage

// File: rtl/fir_sat16.sv
// fir_sat16: drops the Q1.15 fraction of an accumulator (floor) and clamps the result to a 16-bit sample
module fir_sat16 import pariVo_fir_pkg::*; (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] sat
);
    localparam acc_t MAXV = acc_t'(32767);
    localparam acc_t MINV = acc_t'(-32768);
    acc_t sh;
    assign sh = acc >>> FRAC_BITS;
    assign sat = sh > MAXV ? 16'h7fff : sh < MINV ? 16'h8000 : sh[DATA_W-1:0];
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: per accepted sample, walks get_tap through 8 taps, multiply-accumulates
// against the delay line and presents one saturated filtered sample
module fir_tap_sequencer import pariVo_fir_pkg::*; (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cfg_filterNum,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [3:0]  filterNum,
    output logic [2:0]  tapnum,
    input  logic [15:0] tapcoeff,
    output logic [15:0] out_sample,
    output logic        out_valid,
    input  logic        out_ready
);
    fir_state_t state, state_nx;
    sample_t x [NTAPS];
    acc_t acc, acc_nx;
    logic [3:0] cnt;
    logic signed [2*DATA_W-1:0] prod;
    sample_t sat;
    // coefficient arrives one cycle after its tapnum, so it pairs with x[cnt-1]
    assign prod = 32'($signed(tapcoeff)) * 32'(x[TAP_W'(cnt - 4'd1)]);
    assign acc_nx = acc + acc_t'(prod);
    fir_sat16 u_sat (.acc(acc_nx), .sat(sat));
    always_comb begin
        sample_ready = state == IDLE;
        tapnum = state == MAC ? (cnt[3] ? 3'd7 : cnt[2:0]) : 3'd0;
        state_nx = state;
        unique case (state)
            IDLE: if (sample_valid) state_nx = MAC;
            MAC: if (cnt == 4'd8) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= !reset ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (!reset) begin
            x <= '{default: '0};
            acc <= '0;
            cnt <= '0;
            filterNum <= '0;
            out_sample <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE && sample_valid) begin
                x[0] <= sample_in;
                for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
                filterNum <= cfg_filterNum;
                acc <= '0;
                cnt <= '0;
            end
            if (state == MAC) begin
                cnt <= cnt + 4'd1;
                if (cnt != 4'd0) acc <= acc_nx;
                if (cnt == 4'd8) begin
                    out_sample <= sat;
                    out_valid <= 1'b1;
                end
            end
            if (state == DONE && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed and random samples against a bench coefficient ROM and
// an arithmetic FIR reference built from the sample history
module tb_fir_tap_sequencer;
    logic clk = 1'b0, reset = 1'b0;
    logic [3:0] cfg_filterNum = '0, filterNum;
    logic [15:0] sample_in = '0, tapcoeff = '0, out_sample;
    logic sample_valid = 1'b0, sample_ready, out_valid, out_ready = 1'b0;
    logic [2:0] tapnum;
    int tests = 0, fails = 0;
    logic [15:0] rom [16][8];
    longint hist [8];
    logic [15:0] got;

    fir_tap_sequencer dut (
        .clk(clk), .reset(reset), .cfg_filterNum(cfg_filterNum), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .filterNum(filterNum),
        .tapnum(tapnum), .tapcoeff(tapcoeff), .out_sample(out_sample), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    // get_tap stand-in: registered ROM, data one cycle after tapnum
    always @(posedge clk) tapcoeff <= rom[filterNum][tapnum];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [3:0] f);
        longint sum = 0, r;
        for (int k = 0; k < 8; k++) sum += longint'($signed(rom[f][k])) * hist[k];
        r = sum >>> 15;
        r = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
        return 16'(r);
    endfunction

    task automatic clear_hist();
        for (int k = 0; k < 8; k++) hist[k] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_hist();
    endtask

    task automatic run(input logic [15:0] s, input logic [3:0] f, input int stall, output logic [15:0] res);
        logic [15:0] exp;
        sample_in = s;
        cfg_filterNum = f;
        sample_valid = 1'b1;
        chk("ready_idle", 16'(sample_ready), 16'd1);
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(s));
        exp = model(f);
        @(negedge clk);
        sample_valid = 1'b0;
        cfg_filterNum = 4'($urandom);
        for (int i = 0; i < 9; i++) begin
            chk("tapnum", 16'(tapnum), 16'(i > 7 ? 7 : i));
            chk("valid_early", 16'(out_valid), 16'd0);
            chk("filt_hold", 16'(filterNum), 16'(f));
            @(negedge clk);
        end
        chk("valid_rise", 16'(out_valid), 16'd1);
        chk("out_sample", out_sample, exp);
        res = out_sample;
        for (int i = 0; i < stall; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'($urandom);
            cfg_filterNum = 4'($urandom);
            @(negedge clk);
            chk("stall_valid", 16'(out_valid), 16'd1);
            chk("stall_out", out_sample, exp);
            chk("stall_ready", 16'(sample_ready), 16'd0);
            chk("stall_filt", 16'(filterNum), 16'(f));
        end
        out_ready = 1'b1;
        sample_valid = 1'b1;
        sample_in = 16'($urandom);
        @(negedge clk);
        out_ready = 1'b0;
        sample_valid = 1'b0;
        chk("valid_clear", 16'(out_valid), 16'd0);
        chk("no_accept_done", 16'(sample_ready), 16'd1);
    endtask

    initial begin
        for (int f = 0; f < 16; f++)
            for (int k = 0; k < 8; k++) rom[f][k] = 16'($urandom);
        rom[0][2] = 16'h0002;
        rom[10][2] = 16'h1312;
        for (int k = 0; k < 8; k++) begin
            rom[1][k] = 16'h1000;
            rom[2][k] = 16'h7fff;
        end
        clear_hist();
        repeat (2) @(negedge clk);
        chk("rst_ready", 16'(sample_ready), 16'd1);
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_out", out_sample, 16'd0);
        chk("rst_tap", 16'(tapnum), 16'd0);
        chk("rst_filt", 16'(filterNum), 16'd0);
        reset = 1'b1;
        run(16'h7fff, 4'h0, 0, got);
        run(16'h0000, 4'h0, 0, got);
        run(16'h0000, 4'h0, 0, got);
        chk("impulse_f0", got, 16'h0001);
        do_reset();
        run(16'h7fff, 4'ha, 0, got);
        run(16'h0000, 4'ha, 0, got);
        run(16'h0000, 4'ha, 0, got);
        chk("impulse_fa", got, 16'h1311);
        do_reset();
        for (int i = 0; i < 8; i++) run(16'h4000, 4'h1, 0, got);
        chk("dc_f1", got, 16'h4000);
        for (int i = 0; i < 8; i++) run(16'h7fff, 4'h2, 0, got);
        chk("sat_pos", got, 16'h7fff);
        for (int i = 0; i < 8; i++) run(16'h8000, 4'h2, 0, got);
        chk("sat_neg", got, 16'h8000);
        run(16'h2345, 4'h7, 5, got);
        run(16'hc001, 4'h7, 0, got);
        for (int i = 0; i < 30; i++) run(16'($urandom), 4'($urandom), int'($urandom_range(0, 3)), got);
        sample_in = 16'h1234;
        cfg_filterNum = 4'h3;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_tap4", 16'(tapnum), 16'd4);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_hist();
        chk("mid_ready", 16'(sample_ready), 16'd1);
        chk("mid_valid", 16'(out_valid), 16'd0);
        chk("mid_tap", 16'(tapnum), 16'd0);
        chk("mid_filt", 16'(filterNum), 16'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mid_no_out", 16'(out_valid), 16'd0);
        end
        run(16'h7fff, 4'h5, 0, got);
        chk("mid_impulse", got, 16'((longint'($signed(rom[5][0])) * 32767) >>> 15));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
